// File: rtl/wino_out_pkg.sv
// wino_out_pkg
// Shared constants, types and helpers for the output tile accumulator.
//   - Tile geometry and datapath widths
//   - FSM state encoding
//   - Input/accumulator tile array types
//   - sign_ext_in: widen an incoming element to accumulator width
//   - sat_to_out: clamp an accumulator value to the memory write width
package wino_out_pkg;

  localparam int TILE       = 6;
  localparam int SMALL_TILE = 4;
  localparam int IN_W       = 12;
  localparam int ACC_W      = 16;
  localparam int OUT_W      = 12;
  localparam int IDX_W      = 9;
  localparam int OD_W       = 8;
  localparam int CNT_W      = 5;
  localparam int RC_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic signed [IN_W-1:0]  in_elem_t;
  typedef logic signed [ACC_W-1:0] acc_elem_t;
  typedef logic signed [OUT_W-1:0] out_elem_t;

  typedef in_elem_t  in_tile_t  [TILE][TILE];
  typedef acc_elem_t acc_tile_t [TILE][TILE];

  localparam acc_elem_t SAT_MAX = acc_elem_t'((1 << (OUT_W - 1)) - 1);
  localparam acc_elem_t SAT_MIN = acc_elem_t'(-(1 << (OUT_W - 1)));

  function automatic acc_elem_t sign_ext_in(input in_elem_t v);
    return {{(ACC_W - IN_W){v[IN_W-1]}}, v};
  endfunction

  function automatic out_elem_t sat_to_out(input acc_elem_t v);
    if (v > SAT_MAX) begin
      return out_elem_t'(SAT_MAX);
    end
    if (v < SAT_MIN) begin
      return out_elem_t'(SAT_MIN);
    end
    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/output_tile_accumulator_if.sv
// output_tile_accumulator_if
// Bundles the PE result port (tile + tags, ready back) and the output
// memory write port (address/data + ready back).
//   master : PE array / memory side (drives tiles and write-ready)
//   slave  : the accumulator (drives tile-ready and write requests)
interface output_tile_accumulator_if;
  import wino_out_pkg::*;

  in_tile_t          tile_i;
  logic              tile_valid_i;
  logic [OD_W-1:0]   tile_od_i;
  logic [IDX_W-1:0]  tile_x_i;
  logic [IDX_W-1:0]  tile_y_i;
  logic              tile_size_type_i;
  logic [CNT_W-1:0]  id_count_i;
  logic              tile_ready_o;

  logic              mem_wr_en_o;
  logic [OD_W-1:0]   mem_wr_od_o;
  logic [IDX_W-1:0]  mem_wr_x_o;
  logic [IDX_W-1:0]  mem_wr_y_o;
  out_elem_t         mem_wr_data_o;
  logic              mem_wr_ready_i;

  modport master (
    output tile_i, tile_valid_i, tile_od_i, tile_x_i, tile_y_i,
           tile_size_type_i, id_count_i, mem_wr_ready_i,
    input  tile_ready_o, mem_wr_en_o, mem_wr_od_o, mem_wr_x_o,
           mem_wr_y_o, mem_wr_data_o
  );

  modport slave (
    input  tile_i, tile_valid_i, tile_od_i, tile_x_i, tile_y_i,
           tile_size_type_i, id_count_i, mem_wr_ready_i,
    output tile_ready_o, mem_wr_en_o, mem_wr_od_o, mem_wr_x_o,
           mem_wr_y_o, mem_wr_data_o
  );

endinterface

// File: rtl/tile_drain_seq.sv
// tile_drain_seq
// Raster (row, col) walker for draining a tile, column fastest.
//   clk, reset  : clock, synchronous active-low reset
//   active_i    : high while the tile is being drained
//   size_type_i : 0 -> 6x6 walk, 1 -> 4x4 walk
//   advance_i   : current element accepted, step to the next one
//   row_o/col_o : element currently presented
//   last_o      : current element is the final one of the tile
module tile_drain_seq
  import wino_out_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            active_i,
  input  logic            size_type_i,
  input  logic            advance_i,
  output logic [RC_W-1:0] row_o,
  output logic [RC_W-1:0] col_o,
  output logic            last_o
);

  logic [RC_W-1:0] row_q, row_d;
  logic [RC_W-1:0] col_q, col_d;
  logic [RC_W-1:0] edge_max;

  assign edge_max = size_type_i ? RC_W'(SMALL_TILE - 1) : RC_W'(TILE - 1);
  assign last_o   = (row_q == edge_max) && (col_q == edge_max);
  assign row_o    = row_q;
  assign col_o    = col_q;

  // Counters sit at zero whenever not draining, so DRAIN entry always
  // starts from element (0,0) and wrapping after the last element is free.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (!active_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == edge_max) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + RC_W'(1);
      end else begin
        col_d = col_q + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/output_tile_accumulator.sv
// output_tile_accumulator
// Sums partial 6x6 result tiles from one PE across input depth, then
// writes the finished 4x4 or 6x6 tile to output memory, one saturated
// element per accepted write.
//   clk, reset   : clock, synchronous active-low reset
//   bus (slave)  : PE tile port in, memory write port out
//   tile_done_o  : pulse on the accepted final write of a tile
//   busy_o       : block is accumulating or draining
//   err_drop_o   : sticky, a tile was discarded
//
// state | meaning
// IDLE  | waiting for the first partial tile of a new output tile
// ACCUM | summing further partial tiles with matching od/x/y tags
// DRAIN | writing the accumulated tile to memory, tiles refused
module output_tile_accumulator
  import wino_out_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  output_tile_accumulator_if.slave   bus,
  output logic                       tile_done_o,
  output logic                       busy_o,
  output logic                       err_drop_o
);

  state_e           state_q, state_d;
  acc_tile_t        acc_q, acc_d;
  logic [OD_W-1:0]  od_q, od_d;
  logic [IDX_W-1:0] x_q, x_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic             size_q, size_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] seen_q, seen_d;
  logic             err_q, err_d;

  logic             tile_ready;
  logic             accept;
  logic             tag_match;
  logic             draining;
  logic [RC_W-1:0]  row;
  logic [RC_W-1:0]  col;
  logic             last;

  assign draining   = (state_q == DRAIN);
  assign tile_ready = !draining;
  assign accept     = bus.tile_valid_i && tile_ready;
  assign tag_match  = (bus.tile_od_i == od_q) && (bus.tile_x_i == x_q) &&
                      (bus.tile_y_i == y_q);

  tile_drain_seq u_drain_seq (
    .clk         (clk),
    .reset       (reset),
    .active_i    (draining),
    .size_type_i (size_q),
    .advance_i   (bus.mem_wr_ready_i),
    .row_o       (row),
    .col_o       (col),
    .last_o      (last)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    od_d        = od_q;
    x_d         = x_q;
    y_d         = y_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    err_d       = err_q;
    tile_done_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int r = 0; r < TILE; r++) begin
            for (int c = 0; c < TILE; c++) begin
              acc_d[r][c] = sign_ext_in(bus.tile_i[r][c]);
            end
          end
          od_d   = bus.tile_od_i;
          x_d    = bus.tile_x_i;
          y_d    = bus.tile_y_i;
          size_d = bus.tile_size_type_i;
          // A zero count would never terminate; treat it as a single tile.
          cnt_d  = (bus.id_count_i == '0) ? CNT_W'(1) : bus.id_count_i;
          seen_d = CNT_W'(1);
          state_d = (cnt_d == CNT_W'(1)) ? DRAIN : ACCUM;
        end
      end

      ACCUM: begin
        if (accept) begin
          if (tag_match) begin
            for (int r = 0; r < TILE; r++) begin
              for (int c = 0; c < TILE; c++) begin
                acc_d[r][c] = acc_q[r][c] + sign_ext_in(bus.tile_i[r][c]);
              end
            end
            seen_d = seen_q + CNT_W'(1);
            if (seen_d == cnt_q) begin
              state_d = DRAIN;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      DRAIN: begin
        // Upstream cannot be stalled, so anything offered now is lost.
        if (bus.tile_valid_i) begin
          err_d = 1'b1;
        end
        if (bus.mem_wr_ready_i && last) begin
          tile_done_o = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '{default: '0};
      od_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      size_q  <= 1'b0;
      cnt_q   <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      od_q    <= od_d;
      x_q     <= x_d;
      y_q     <= y_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

  // Write address/data are zeroed outside DRAIN so the bus is quiet when idle.
  assign bus.tile_ready_o  = tile_ready;
  assign bus.mem_wr_en_o   = draining;
  assign bus.mem_wr_od_o   = draining ? od_q : '0;
  assign bus.mem_wr_x_o    = draining ? x_q + IDX_W'(row) : '0;
  assign bus.mem_wr_y_o    = draining ? y_q + IDX_W'(col) : '0;
  assign bus.mem_wr_data_o = draining ? sat_to_out(acc_q[row][col]) : '0;

  assign busy_o     = (state_q != IDLE);
  assign err_drop_o = err_q;

endmodule
